// File: rtl/udp_vlg_pkg.sv
// Shared types and constants for the UDP transmit path.
package udp_vlg_pkg;

    localparam int unsigned UDP_MAX_PAYLOAD = 1472;

    typedef enum logic [2:0] {
        TXQ_IDLE,
        TXQ_FILL,
        TXQ_PREP,
        TXQ_SEND,
        TXQ_DONE
    } udp_txq_fsm_t;

    // Idle counter width: wide enough to reach the timeout, never zero bits.
    function automatic int unsigned txq_idle_w(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/udp_vlg_txq_ram.sv
// Simple dual-port byte RAM with registered, enable-held read for block-RAM inference.
module udp_vlg_txq_ram #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdat,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdat
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [7:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdat;
        end
    end

    // Read port: output register holds its value while ren is low, which doubles
    // as the prefetch/hold stage seen by the transmitter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdat <= '0;
        end else if (ren) begin
            rdat <= mem[raddr];
        end
    end

endmodule

// File: rtl/udp_vlg_tx_queue.sv
// Byte-stream packetiser: buffers user bytes into a datagram and replays it
// to the UDP transmitter with length and header fields held stable.
module udp_vlg_tx_queue
    import udp_vlg_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = UDP_MAX_PAYLOAD,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned TIMEOUT     = 1250,
    parameter int unsigned VERBOSE     = 1,
    parameter string       DUT_STRING  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_dat,
    input  logic        in_val,
    input  logic        in_lst,
    output logic        in_rdy,
    input  logic [31:0] cfg_dst_ip,
    input  logic [15:0] cfg_src_port,
    input  logic [15:0] cfg_dst_port,
    output logic [7:0]  out_dat,
    output logic        out_val,
    output logic        out_sof,
    output logic        out_eof,
    input  logic        out_rdy,
    output logic [15:0] out_len,
    output logic [31:0] out_dst_ip,
    output logic [15:0] out_src_port,
    output logic [15:0] out_dst_port
);

    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned IDLE_W  = txq_idle_w(TIMEOUT);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = '1;

    udp_txq_fsm_t      state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  out_idx;
    logic [ADDR_W-1:0] rd_ptr;
    logic [IDLE_W-1:0] idle;

    logic              accept_c;
    logic              timeout_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic [ADDR_W-1:0] waddr_c;
    logic              ren_c;
    logic [ADDR_W-1:0] raddr_c;

    // Message hooks carry no logic in hardware.
    logic unused_dbg;
    assign unused_dbg = (VERBOSE != 0) ^ (DUT_STRING != "");

    // Handshake, close and RAM port decode.
    assign accept_c  = in_val & in_rdy;
    assign cnt_inc_c = cnt + CNT_W'(1);
    assign timeout_c = (TIMEOUT != 0) && !accept_c && (idle == IDLE_W'(TO_LAST));
    assign waddr_c   = (state == TXQ_IDLE) ? '0 : cnt[ADDR_W-1:0];
    assign ren_c     = (state == TXQ_PREP) || ((state == TXQ_SEND) && out_rdy && !out_eof);
    assign raddr_c   = (state == TXQ_PREP) ? '0 : rd_ptr;

    udp_vlg_txq_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .wen   (accept_c),
        .waddr (waddr_c),
        .wdat  (in_dat),
        .ren   (ren_c),
        .raddr (raddr_c),
        .rdat  (out_dat)
    );

    // Packet FSM: fill, close, replay with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= TXQ_IDLE;
            in_rdy       <= 1'b0;
            cnt          <= '0;
            idle         <= '0;
            rd_ptr       <= '0;
            out_idx      <= '0;
            out_val      <= 1'b0;
            out_sof      <= 1'b0;
            out_eof      <= 1'b0;
            out_len      <= '0;
            out_dst_ip   <= '0;
            out_src_port <= '0;
            out_dst_port <= '0;
        end else begin
            case (state)
                TXQ_IDLE: begin
                    in_rdy <= 1'b1;
                    idle   <= '0;
                    if (accept_c) begin
                        cnt          <= CNT_W'(1);
                        out_dst_ip   <= cfg_dst_ip;
                        out_src_port <= cfg_src_port;
                        out_dst_port <= cfg_dst_port;
                        if (in_lst || (MAX_PAYLOAD == 1)) begin
                            state  <= TXQ_PREP;
                            in_rdy <= 1'b0;
                        end else begin
                            state <= TXQ_FILL;
                        end
                    end
                end

                TXQ_FILL: begin
                    if (accept_c) begin
                        cnt  <= cnt_inc_c;
                        idle <= '0;
                        if (in_lst || (cnt_inc_c == CNT_W'(MAX_PAYLOAD))) begin
                            state  <= TXQ_PREP;
                            in_rdy <= 1'b0;
                        end
                    end else begin
                        if (idle != IDLE_MAX) begin
                            idle <= idle + IDLE_W'(1);
                        end
                        if (timeout_c) begin
                            state  <= TXQ_PREP;
                            in_rdy <= 1'b0;
                        end
                    end
                end

                TXQ_PREP: begin
                    out_len <= 16'(cnt);
                    rd_ptr  <= ADDR_W'(1);
                    out_idx <= '0;
                    out_val <= 1'b1;
                    out_sof <= 1'b1;
                    out_eof <= (cnt == CNT_W'(1));
                    state   <= TXQ_SEND;
                end

                TXQ_SEND: begin
                    if (out_rdy) begin
                        if (out_eof) begin
                            out_val <= 1'b0;
                            out_sof <= 1'b0;
                            out_eof <= 1'b0;
                            state   <= TXQ_DONE;
                        end else begin
                            out_idx <= out_idx + CNT_W'(1);
                            rd_ptr  <= rd_ptr + ADDR_W'(1);
                            out_sof <= 1'b0;
                            out_eof <= ((out_idx + CNT_W'(2)) == cnt);
                        end
                    end
                end

                TXQ_DONE: begin
                    cnt    <= '0;
                    in_rdy <= 1'b1;
                    state  <= TXQ_IDLE;
                end

                default: begin
                    state  <= TXQ_IDLE;
                    in_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_vlg_tx_queue.sv
// Randomised scoreboard bench for udp_vlg_tx_queue.
module tb_udp_vlg_tx_queue;

    localparam int unsigned MAXP = 48;
    localparam int unsigned AW   = 6;
    localparam int unsigned TMO  = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  in_dat;
    logic        in_val;
    logic        in_lst;
    logic        in_rdy;
    logic [31:0] cfg_dst_ip;
    logic [15:0] cfg_src_port;
    logic [15:0] cfg_dst_port;
    logic [7:0]  out_dat;
    logic        out_val;
    logic        out_sof;
    logic        out_eof;
    logic        out_rdy;
    logic [15:0] out_len;
    logic [31:0] out_dst_ip;
    logic [15:0] out_src_port;
    logic [15:0] out_dst_port;

    udp_vlg_tx_queue #(
        .MAX_PAYLOAD (MAXP),
        .ADDR_W      (AW),
        .TIMEOUT     (TMO),
        .VERBOSE     (0),
        .DUT_STRING  ("tb")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_dat       (in_dat),
        .in_val       (in_val),
        .in_lst       (in_lst),
        .in_rdy       (in_rdy),
        .cfg_dst_ip   (cfg_dst_ip),
        .cfg_src_port (cfg_src_port),
        .cfg_dst_port (cfg_dst_port),
        .out_dat      (out_dat),
        .out_val      (out_val),
        .out_sof      (out_sof),
        .out_eof      (out_eof),
        .out_rdy      (out_rdy),
        .out_len      (out_len),
        .out_dst_ip   (out_dst_ip),
        .out_src_port (out_src_port),
        .out_dst_port (out_dst_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          len;
        logic [31:0] ip;
        logic [15:0] sp;
        logic [15:0] dp;
        int          close_cyc;
    } pkt_t;

    pkt_t       exp_pkts[$];
    logic [7:0] exp_bytes[$];

    // ---------------- reference model: datagram assembly from accepted bytes
    logic [7:0] cur[$];
    bit         open   = 0;
    int         idle   = 0;
    bit         busy   = 0;
    int         rdy_ok = 2;
    pkt_t       hdr;

    task automatic close_pkt();
        hdr.len       = cur.size();
        hdr.close_cyc = cyc;
        foreach (cur[i]) exp_bytes.push_back(cur[i]);
        exp_pkts.push_back(hdr);
        cur.delete();
        open = 0;
        idle = 0;
        busy = 1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cur.delete();
            exp_pkts.delete();
            exp_bytes.delete();
            open   = 0;
            idle   = 0;
            busy   = 0;
            rdy_ok = cyc + 2;
        end else begin
            chk("in_rdy", 64'(in_rdy), 64'(!busy && (cyc >= rdy_ok)));
            if (out_val && out_rdy && out_eof) begin
                busy   = 0;
                rdy_ok = cyc + 2;
            end
            if (in_val && in_rdy) begin
                if (!open) begin
                    hdr.ip = cfg_dst_ip;
                    hdr.sp = cfg_src_port;
                    hdr.dp = cfg_dst_port;
                    open   = 1;
                end
                cur.push_back(in_dat);
                idle = 0;
                if (in_lst || (cur.size() == MAXP)) close_pkt();
            end else if (open) begin
                idle++;
                if (idle == TMO) close_pkt();
            end
        end
    end

    // ---------------- monitor: pops expectations when the DUT presents bytes
    bit         in_pkt    = 0;
    int         idx       = 0;
    int         pkts_done = 0;
    pkt_t       cp;
    logic [7:0] p_dat = '0;
    logic       p_val = 1'b0;
    logic       p_rdy = 1'b0;
    logic       p_sof = 1'b0;
    logic       p_eof = 1'b0;
    bit         rst_d = 0;

    always @(negedge clk) begin
        if (rst_d) begin
            chk("reset_ctl", 64'({in_rdy, out_val, out_sof, out_eof, out_dat, out_len}), 64'(0));
            chk("reset_hdr", {out_dst_ip, out_src_port, out_dst_port}, 64'(0));
        end
        if (rst) begin
            in_pkt = 0;
        end else begin
            if (in_pkt && p_val && !p_rdy)
                chk("stall_hold", 64'({out_val, out_sof, out_eof, out_dat}),
                    64'({p_val, p_sof, p_eof, p_dat}));
            if (out_val && !in_pkt) begin
                if (exp_pkts.size() == 0) begin
                    chk("spurious_out_val", 64'(out_val), 64'(0));
                end else begin
                    cp     = exp_pkts[0];
                    in_pkt = 1;
                    idx    = 0;
                    chk("sof_latency", 64'(cyc), 64'(cp.close_cyc + 2));
                    chk("out_len", 64'(out_len), 64'(cp.len));
                    chk("out_hdr", {out_dst_ip, out_src_port, out_dst_port}, {cp.ip, cp.sp, cp.dp});
                end
            end else if (!out_val && in_pkt) begin
                chk("out_val_gap", 64'(out_val), 64'(1));
            end
            if (in_pkt && out_val && out_rdy) begin
                if (exp_bytes.size() == 0) begin
                    chk("byte_underflow", 64'(0), 64'(1));
                end else begin
                    chk("out_dat", 64'(out_dat), 64'(exp_bytes[0]));
                    void'(exp_bytes.pop_front());
                end
                chk("out_sof", 64'(out_sof), 64'(idx == 0));
                chk("out_eof", 64'(out_eof), 64'(idx == cp.len - 1));
                chk("len_hold", 64'(out_len), 64'(cp.len));
                idx++;
                if (idx == cp.len) begin
                    void'(exp_pkts.pop_front());
                    in_pkt = 0;
                    pkts_done++;
                end
            end
        end
        p_dat = out_dat;
        p_val = out_val;
        p_rdy = out_rdy;
        p_sof = out_sof;
        p_eof = out_eof;
        rst_d = rst;
    end

    // ---------------- out_rdy driver: 0 = always ready, 1 = random 50%, 2 = stalled
    int rdy_mode = 0;
    initial begin
        out_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = 1'($urandom_range(0, 1));
                default: out_rdy = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus
    task automatic send(input logic [7:0] d, input bit lst, input int gap);
        in_val = 1'b0;
        repeat (gap) begin
            in_lst = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_dat = d;
        in_lst = lst;
        in_val = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_rdy) break;
            if (t > 4000) begin
                chk("send_timeout", 64'(1), 64'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
        in_val = 1'b0;
        in_lst = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((open || busy || (exp_pkts.size() != 0) || in_pkt) && (t < 4000)) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 4000) chk("drain_timeout", 64'(1), 64'(0));
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int exp_total = 0;

    initial begin
        rst          = 1'b1;
        in_val       = 1'b0;
        in_lst       = 1'b0;
        in_dat       = '0;
        cfg_dst_ip   = 32'hC0A8_0001;
        cfg_src_port = 16'd4000;
        cfg_dst_port = 16'd5000;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;

        // Short packet 01..04.
        for (int i = 1; i <= 4; i++) send(8'(i), i == 4, 0);
        exp_total += 1;
        drain();

        // Continuous stream longer than the payload limit: 48 + 48 + 4.
        for (int i = 0; i < 100; i++) send(8'(i * 7 + 3), i == 99, 0);
        exp_total += 3;
        drain();

        // Exactly MAXP bytes with in_lst on the last: one packet only.
        for (int i = 0; i < int'(MAXP); i++) send(8'($urandom), i == int'(MAXP) - 1, 0);
        exp_total += 1;
        drain();

        // Single-byte packet.
        send(8'hA5, 1'b1, 0);
        exp_total += 1;
        drain();

        // Ten bytes, no last flag: closed by the idle timeout.
        for (int i = 0; i < 10; i++) send(8'($urandom), 1'b0, $urandom_range(0, 2));
        exp_total += 1;
        drain();

        // Random back-pressure on a 40-byte packet.
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) send(8'($urandom), i == 39, 0);
        exp_total += 1;
        drain();
        rdy_mode = 0;

        // Header change after the first byte applies to the next packet.
        cfg_dst_port = 16'h1234;
        send(8'h11, 1'b0, 0);
        cfg_dst_port = 16'h5678;
        send(8'h22, 1'b0, 0);
        send(8'h33, 1'b1, 0);
        send(8'h44, 1'b0, 0);
        send(8'h55, 1'b1, 0);
        exp_total += 2;
        drain();

        // Reset mid-fill discards the partial packet.
        for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, 0);
        pulse_rst();

        // Reset mid-send discards the packet; a following short packet goes through.
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) send(8'($urandom), i == 39, 0);
        repeat (6) @(posedge clk);
        #1;
        pulse_rst();
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) send(8'(8'hE0 + i), i == 2, 0);
        exp_total += 1;
        drain();

        // Random packets, random gaps, random back-pressure.
        rdy_mode = 1;
        for (int p = 0; p < 25; p++) begin
            int len;
            len          = $urandom_range(1, 60);
            cfg_dst_ip   = $urandom;
            cfg_src_port = 16'($urandom);
            cfg_dst_port = 16'($urandom);
            for (int i = 0; i < len; i++) begin
                send(8'($urandom), i == len - 1, $urandom_range(0, 2));
                if ($urandom_range(0, 7) == 0) cfg_dst_port = 16'($urandom);
            end
            exp_total += (len + int'(MAXP) - 1) / int'(MAXP);
        end
        drain();
        rdy_mode = 0;

        chk("queue_empty", 64'(exp_pkts.size()), 64'(0));
        chk("packet_count", 64'(pkts_done), 64'(exp_total));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
